// File: rtl/score_register_file_pkg.sv
// Shared types for the Smith-Waterman score storage: score word, clear-FSM states, init value.
package sw_pkg;
    localparam int SCORE_W    = 16;
    localparam int SCORE_INIT = 0;

    typedef logic [SCORE_W-1:0] score_t;
    typedef enum logic {CLEAR, IDLE} rf_state_e;
endpackage

// File: rtl/score_register_file_rf_clear_ctrl.sv
// Clear sequencer: walks every entry once after reset or an accepted clr, reporting busy.
module rf_clear_ctrl
    import sw_pkg::*;
#(
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_accept
);
    rf_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_accept = 1'b0;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_d    = CLEAR;
                    cnt_d      = '0;
                    clr_accept = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt_q;
endmodule

// File: rtl/score_register_file.sv
// Parametrised score register file: 1 write port, 2 registered read ports, hardware clear.
// SCORE_RF_WRITE_BYPASS_EN selects write-first forwarding on same-address read/write.
module score_register_file
    import sw_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    DEPTH      = 128,
    parameter int                    ADDR_WIDTH = $clog2(DEPTH),
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(SCORE_INIT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  ra_en,
    input  logic [ADDR_WIDTH-1:0] ra_addr,
    output logic [DATA_WIDTH-1:0] ra_data,
    output logic                  ra_valid,
    input  logic                  rb_en,
    input  logic [ADDR_WIDTH-1:0] rb_addr,
    output logic [DATA_WIDTH-1:0] rb_data,
    output logic                  rb_valid,
    output logic                  addr_err
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  clr_we, clr_accept, idle;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  w_ok, ra_ok, rb_ok, wr_fire;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] ra_data_q, ra_data_d, rb_data_q, rb_data_d;
    logic                  ra_valid_q, ra_valid_d, rb_valid_q, rb_valid_d;
    logic                  addr_err_q, addr_err_d;

    rf_clear_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_clear_ctrl (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .busy       (busy),
        .clr_we     (clr_we),
        .clr_addr   (clr_addr),
        .clr_accept (clr_accept)
    );

    assign idle  = ~busy;
    assign w_ok  = int'(w_addr) < DEPTH;
    assign ra_ok = int'(ra_addr) < DEPTH;
    assign rb_ok = int'(rb_addr) < DEPTH;
    // An accepted clr takes priority over a write in the same cycle.
    assign wr_fire = idle & w_en & w_ok & ~clr;

    always_comb begin
        mem_we    = clr_we | wr_fire;
        mem_waddr = clr_we ? clr_addr : w_addr;
        mem_wdata = clr_we ? INIT_VALUE : w_data;
    end

    always_comb begin
        ra_valid_d = 1'b0;
        ra_data_d  = ra_data_q;
        rb_valid_d = 1'b0;
        rb_data_d  = rb_data_q;
        if (idle && ra_en) begin
            ra_valid_d = 1'b1;
            ra_data_d  = ra_ok ? mem_q[ra_addr] : '0;
`ifdef SCORE_RF_WRITE_BYPASS_EN
            if (ra_ok && wr_fire && (w_addr == ra_addr)) ra_data_d = w_data;
`endif
        end
        if (idle && rb_en) begin
            rb_valid_d = 1'b1;
            rb_data_d  = rb_ok ? mem_q[rb_addr] : '0;
`ifdef SCORE_RF_WRITE_BYPASS_EN
            if (rb_ok && wr_fire && (w_addr == rb_addr)) rb_data_d = w_data;
`endif
        end
    end

    always_comb begin
        addr_err_d = addr_err_q;
        if (clr_accept)
            addr_err_d = 1'b0;
        else if (idle && ((w_en && !w_ok) || (ra_en && !ra_ok) || (rb_en && !rb_ok)))
            addr_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ra_data_q  <= '0;
            rb_data_q  <= '0;
            ra_valid_q <= 1'b0;
            rb_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            ra_data_q  <= ra_data_d;
            rb_data_q  <= rb_data_d;
            ra_valid_q <= ra_valid_d;
            rb_valid_q <= rb_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign ra_data  = ra_data_q;
    assign rb_data  = rb_data_q;
    assign ra_valid = ra_valid_q;
    assign rb_valid = rb_valid_q;
    assign addr_err = addr_err_q;
endmodule
